alu_ctrl_unit: RTL
==================

# alu_ctrl_unit

Parametrised ALU control unit for the RV32 core, decoding ALUOp/funct3/funct7 into the full RV32I operation set plus optional RV32M operations. For multiply/divide it runs a fixed-latency sequencer that stalls the single-cycle datapath and signals start/done to the execute unit. It sits between the main decoder and the ALU/MDU, where the plain combinational ALU decoder used to be.

## Interface
- DATA_WIDTH, 32, datapath width, passed through to package consumers; no logic depends on it.
- CTRL_WIDTH, 5, ALUControl width; must be 5 or more.
- M_EN, 1, 1 enables RV32M decode; 0 makes every M encoding illegal.
- MUL_CYCLES, 4, stall cycles for MUL*; must be 2 or more.
- DIV_CYCLES, 33, stall cycles for DIV*/REM*; must be 2 or more.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  unit enable; 0 freezes the sequencer.
- valid_in  in  1  instruction present this cycle.
- ALUOp  in  3  000 ADD, 001 SUB, 010 funct decode; any other value is illegal.
- op_5  in  1  opcode bit 5 (R-type when 1).
- funct3  in  3  instruction funct3.
- funct7_5  in  1  funct7 bit 5.
- funct7_0  in  1  funct7 bit 0 (M-extension select).
- flush  in  1  abort any in-flight M op.
- ALUControl  out  CTRL_WIDTH  operation code.
- is_muldiv  out  1  current or held op is an M op.
- md_start  out  1  one-cycle pulse when an M op is issued.
- md_done  out  1  one-cycle pulse when the M result is valid.
- stall  out  1  hold PC and pipeline.
- illegal  out  1  unsupported encoding.

## Operation
- Encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- ALUOp=010 with an I/R-type encoding:
  - funct3 000: SUB if op_5 and funct7_5, otherwise ADD.
  - funct3 001: SLL.
  - funct3 010: SLT.
  - funct3 011: SLTU.
  - funct3 100: XOR.
  - funct3 101: SRA if funct7_5, otherwise SRL.
  - funct3 110: OR.
  - funct3 111: AND.
- M op condition: op_5, funct7_0 and ALUOp=010 all set. The code is 10 plus funct3.
  - With M_EN=0, an M op decodes as ADD and raises illegal.
- Illegal ALUOp decodes as ADD and raises illegal. illegal is gated by valid_in and en.
- Sequencer FSM has three states: IDLE, BUSY, DONE.
  - IDLE: ALUControl and is_muldiv are combinational from the inputs. An M op with valid_in and en raises md_start, latches the op, loads the counter with LAT-2 and moves to BUSY. LAT is MUL_CYCLES for codes 10–13 and DIV_CYCLES for codes 14–17.
  - BUSY: outputs the latched op. The counter decrements while en=1 and holds while en=0. Count 0 with en=1 moves to DONE.
  - DONE: outputs the latched op and raises md_done, then returns to IDLE unconditionally. valid_in is ignored in this state.
- stall = (IDLE and md_start) or BUSY.
- en=0 in IDLE forces ALUControl=ADD and holds all pulses and illegal at 0.
- flush has priority over everything except reset. In the flush cycle stall, md_start and md_done are 0, and the next state is IDLE.
- Counter width is clog2(max(MUL_CYCLES, DIV_CYCLES)).

## Timing
- Reset: while rstn=0, every output is 0, and at the clock edge the state goes to IDLE and the counter to 0. Reset mid-operation aborts with no md_done.
- Non-M ops have zero latency: purely combinational, with no stall.
- M op issued in cycle T:
  - stall is high in cycles T through T+LAT-1 (LAT cycles).
  - md_start is high in T only.
  - md_done is high in T+LAT, where stall is 0, so the PC advances that cycle.
- en=0 during BUSY stretches the stall by one cycle per low cycle.
- flush in cycle T+k clears stall combinationally in that cycle; IDLE follows in T+k+1.

## Structure
- Package alu_ctrl_pkg holds the op encodings, the ALUOp codes, the FSM state typedef and the latency-select function.
- Sub-module md_seq holds the FSM, counter and latched op. The top-level holds the combinational decode.

## Test plan
- Full RV32I decode, ALUOp=010, valid_in=1, sweeping funct3/op_5/funct7_5: funct3=000, op_5=1, funct7_5=1 gives 1; funct3=101, funct7_5=1 gives 9; stall=0 throughout.
- MUL (funct3 000, funct7_0=1, op_5=1) at T with MUL_CYCLES=4: md_start at T; stall high T..T+3; md_done at T+4 with ALUControl=10.
- DIVU with DIV_CYCLES=33: stall high for exactly 33 cycles; md_done at T+33 with ALUControl=15.
- DIV with en=0 for 3 cycles mid-BUSY: md_done at T+36.
- Boundary aborts:
  - flush at T+2 of DIV: stall=0 in T+2, no md_done.
  - rstn=0 at T+5: all outputs 0, IDLE next.
- Illegal encodings:
  - M_EN=0 with an M op: ALUControl=0, illegal=1, no stall.
  - ALUOp=111: illegal=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_ctrl_pkg : op encodings, ALUOp codes, sequencer state, latency |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package alu_ctrl_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SLTU   = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // DIV/DIVU/REM/REMU share the divider latency, all others the multiplier's.
    function automatic int unsigned md_latency(input logic [4:0] op,
                                               input int unsigned mul_cycles,
                                               input int unsigned div_cycles);
        return (op >= OP_DIV) ? div_cycles : mul_cycles;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | md_seq   : fixed-latency multiply/divide sequencer with held op    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module md_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  logic       i_flush,
    input  logic       i_issue,
    input  logic [4:0] i_op,
    output logic       o_md_start,
    output logic       o_md_done,
    output logic       o_stall,
    output logic       o_held,
    output logic [4:0] o_op
);

    localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_op;

    logic w_idle;
    logic w_busy;
    logic w_done;

    assign w_idle = (r_state == ST_IDLE);
    assign w_busy = (r_state == ST_BUSY);
    assign w_done = (r_state == ST_DONE);

    // Pulses are killed combinationally by flush and by reset.
    assign o_md_start = rstn & ~i_flush & w_idle & i_issue;
    assign o_md_done  = rstn & ~i_flush & w_done;
    assign o_stall    = rstn & ~i_flush & (o_md_start | w_busy);
    assign o_held     = w_busy | w_done;
    assign o_op       = r_op;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_ADD;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_issue) begin
                        r_state <= ST_BUSY;
                        r_op    <= i_op;
                        r_cnt   <= CNT_W'(md_latency(i_op, MUL_CYCLES, DIV_CYCLES) - 32'd2);
                    end
                end
                ST_BUSY: begin
                    if (i_en) begin
                        if (r_cnt == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_ctrl_unit : RV32I/M ALU control decode with M-op stall control |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 5,
    parameter bit          M_EN       = 1'b1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  valid_in,
    input  logic [2:0]            ALUOp,
    input  logic                  op_5,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  funct7_0,
    input  logic                  flush,
    output logic [CTRL_WIDTH-1:0] ALUControl,
    output logic                  is_muldiv,
    output logic                  md_start,
    output logic                  md_done,
    output logic                  stall,
    output logic                  illegal
);

    if (CTRL_WIDTH < 5 || MUL_CYCLES < 2 || DIV_CYCLES < 2 || DATA_WIDTH < 1) begin : g_param_check
        $error("alu_ctrl_unit: invalid parameterisation");
    end

    logic [4:0] w_dec_op;
    logic       w_dec_ill;
    logic       w_m_op;
    logic       w_issue;
    logic       w_held;
    logic [4:0] w_held_op;
    logic       w_seq_start;
    logic       w_seq_done;
    logic       w_seq_stall;

    always_comb begin
        w_dec_op  = OP_ADD;
        w_dec_ill = 1'b0;
        w_m_op    = 1'b0;
        case (ALUOp)
            ALUOP_ADD: w_dec_op = OP_ADD;
            ALUOP_SUB: w_dec_op = OP_SUB;
            ALUOP_FUNCT: begin
                if (op_5 && funct7_0) begin
                    // M encodings collapse to ADD + illegal when the extension is absent.
                    if (M_EN) begin
                        w_m_op   = 1'b1;
                        w_dec_op = OP_MUL + {2'b00, funct3};
                    end else begin
                        w_dec_ill = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000:  w_dec_op = (op_5 && funct7_5) ? OP_SUB : OP_ADD;
                        3'b001:  w_dec_op = OP_SLL;
                        3'b010:  w_dec_op = OP_SLT;
                        3'b011:  w_dec_op = OP_SLTU;
                        3'b100:  w_dec_op = OP_XOR;
                        3'b101:  w_dec_op = funct7_5 ? OP_SRA : OP_SRL;
                        3'b110:  w_dec_op = OP_OR;
                        default: w_dec_op = OP_AND;
                    endcase
                end
            end
            default: w_dec_ill = 1'b1;
        endcase
    end

    assign w_issue = valid_in & en & w_m_op;

    md_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_seq (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (en),
        .i_flush    (flush),
        .i_issue    (w_issue),
        .i_op       (w_dec_op),
        .o_md_start (w_seq_start),
        .o_md_done  (w_seq_done),
        .o_stall    (w_seq_stall),
        .o_held     (w_held),
        .o_op       (w_held_op)
    );

    assign md_start = w_seq_start;
    assign md_done  = w_seq_done;
    assign stall    = w_seq_stall;

    always_comb begin
        ALUControl = '0;
        is_muldiv  = 1'b0;
        illegal    = 1'b0;
        if (rstn) begin
            if (w_held) begin
                ALUControl = CTRL_WIDTH'(w_held_op);
                is_muldiv  = 1'b1;
            end else if (en) begin
                ALUControl = CTRL_WIDTH'(w_dec_op);
                is_muldiv  = w_m_op;
                illegal    = valid_in & w_dec_ill;
            end
        end
    end

endmodule
`default_nettype wire
